// File: rtl/il_ctrl_pipe.sv
// Registered decode/execute control unit for the instruction-list processor:
// one EX stage, peripheral stall handshake with timeout, branch shadow flush.
module il_ctrl_pipe #(
  parameter int OPCODE_W      = 5,
  parameter int NUM_PERIPH    = 4,
  parameter int PSEL_W        = 2,
  parameter int TIMEOUT_CYC   = 255,
  parameter int BRANCH_SHADOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instValid,
  input  logic [OPCODE_W-1:0]   instOpCode,
  input  logic [1:0]            iomemCode,
  input  logic [PSEL_W-1:0]     periphSel,
  input  logic                  acc0,
  input  logic [NUM_PERIPH-1:0] periphReady,
  output logic                  instReady,
  output logic                  branch,
  output logic [2:0]            accMuxSel,
  output logic                  accEn,
  output logic [1:0]            op2MuxSel,
  output logic [3:0]            aluOpcode,
  output logic                  bitRamEn,
  output logic                  bitRamRw,
  output logic                  byteRamEn,
  output logic                  byteRamRw,
  output logic                  inputRead,
  output logic                  outputRw,
  output logic [NUM_PERIPH-1:0] periphReq,
  output logic                  periphRw,
  output logic                  periphTimeout,
  output logic                  illegalInst
);

  typedef enum logic [1:0] {RUN, PWAIT, SHADOW} state_t;

  localparam logic [OPCODE_W-1:0] OP_LD    = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LDN   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ST    = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_XOR   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JMPC  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_JMPCN = OPCODE_W'(11);

  localparam logic [15:0] CNT_LAST     = 16'(TIMEOUT_CYC - 1);
  localparam logic [1:0]  SHADOW_EXTRA = (BRANCH_SHADOW > 1) ? 2'(BRANCH_SHADOW - 1) : 2'd0;

  state_t                state, stateNext;
  logic                  vld_p1;
  logic [OPCODE_W-1:0]   opCode_p1;
  logic [1:0]            ioCode_p1;
  logic [PSEL_W-1:0]     sel_p1;
  logic [15:0]           waitCnt;
  logic [1:0]            shadowLeft;
  logic                  doneLoad, timeoutHit;
  logic [NUM_PERIPH-1:0] selOh;
  logic                  selReady, accept, drop, load, inPeriph, taken;

  function automatic logic isMemOp(input logic [OPCODE_W-1:0] op);
    return (op >= OP_LD) && (op <= OP_SUB);
  endfunction

  function automatic logic [3:0] aluOf(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LDN:  aluOf = 4'd1;
      OP_AND:  aluOf = 4'd2;
      OP_OR:   aluOf = 4'd3;
      OP_XOR:  aluOf = 4'd4;
      OP_ADD:  aluOf = 4'd5;
      OP_SUB:  aluOf = 4'd6;
      default: aluOf = 4'd0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PERIPH; i++) selOh[i] = (sel_p1 == PSEL_W'(i));
  end

  always_comb begin
    instReady = (state != PWAIT);
    accept    = instValid && instReady;
    selReady  = |(periphReady & selOh);
    taken     = 1'b0;
    if (vld_p1 && (state != PWAIT)) begin
      case (opCode_p1)
        OP_JMP:   taken = 1'b1;
        OP_JMPC:  taken = acc0;
        OP_JMPCN: taken = !acc0;
        default:  taken = 1'b0;
      endcase
    end
    // The slot accepted alongside a taken branch is the first shadow slot.
    drop      = (state == SHADOW) || (taken && (BRANCH_SHADOW > 0));
    load      = accept && !drop;
    inPeriph  = isMemOp(instOpCode) && (iomemCode == 2'b11);
    stateNext = state;
    case (state)
      RUN: begin
        if (taken && (BRANCH_SHADOW > 1)) stateNext = SHADOW;
        else if (load && inPeriph)        stateNext = PWAIT;
      end
      PWAIT:   if (selReady || (waitCnt >= CNT_LAST)) stateNext = RUN;
      SHADOW:  if (accept && (shadowLeft <= 2'd1))     stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= stateNext;
  end

  // EX stage register and handshake bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      opCode_p1  <= '0;
      ioCode_p1  <= '0;
      sel_p1     <= '0;
      waitCnt    <= '0;
      shadowLeft <= '0;
      doneLoad   <= 1'b0;
      timeoutHit <= 1'b0;
    end else begin
      vld_p1 <= load;
      if (load) begin
        opCode_p1 <= instOpCode;
        ioCode_p1 <= iomemCode;
        sel_p1    <= periphSel;
      end
      doneLoad   <= (state == PWAIT) && selReady && (opCode_p1 != OP_ST);
      timeoutHit <= (state == PWAIT) && !selReady && (waitCnt >= CNT_LAST);
      if (state == PWAIT) begin
        if (!selReady && (waitCnt != 16'hFFFF)) waitCnt <= waitCnt + 16'd1;
      end else if (load && inPeriph) begin
        waitCnt <= '0;
      end
      if ((state == RUN) && taken)          shadowLeft <= SHADOW_EXTRA;
      else if ((state == SHADOW) && accept) shadowLeft <= shadowLeft - 2'd1;
    end
  end

  always_comb begin
    branch        = taken;
    accMuxSel     = 3'd0;
    accEn         = 1'b0;
    aluOpcode     = 4'd0;
    bitRamEn      = 1'b0;
    bitRamRw      = 1'b0;
    byteRamEn     = 1'b0;
    byteRamRw     = 1'b0;
    inputRead     = 1'b0;
    outputRw      = 1'b0;
    illegalInst   = 1'b0;
    op2MuxSel     = ioCode_p1;
    periphReq     = (state == PWAIT) ? selOh : '0;
    periphRw      = (state == PWAIT) && (opCode_p1 == OP_ST);
    periphTimeout = timeoutHit;
    if (doneLoad) begin
      accEn     = 1'b1;
      accMuxSel = ((opCode_p1 == OP_LD) || (opCode_p1 == OP_LDN)) ? 3'd3 : 3'd4;
      aluOpcode = aluOf(opCode_p1);
    end
    if (vld_p1 && (state != PWAIT)) begin
      if (opCode_p1 > OP_JMPCN) begin
        illegalInst = 1'b1;
      end else if (isMemOp(opCode_p1) && (ioCode_p1 != 2'b11)) begin
        if (opCode_p1 == OP_ST) begin
          case (ioCode_p1)
            2'b00:   outputRw = 1'b1;
            2'b01:   begin bitRamEn = 1'b1; bitRamRw = 1'b1; end
            default: begin byteRamEn = 1'b1; byteRamRw = 1'b1; end
          endcase
        end else begin
          accEn     = 1'b1;
          aluOpcode = aluOf(opCode_p1);
          accMuxSel = ((opCode_p1 == OP_LD) || (opCode_p1 == OP_LDN)) ? {1'b0, ioCode_p1} : 3'd4;
          case (ioCode_p1)
            2'b00:   inputRead = 1'b1;
            2'b01:   bitRamEn  = 1'b1;
            default: byteRamEn = 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_il_ctrl_pipe.sv
// Directed, table-driven bench for il_ctrl_pipe (TIMEOUT_CYC=4, BRANCH_SHADOW=1).
module tb_il_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset, instValid, acc0;
  logic [4:0] instOpCode;
  logic [1:0] iomemCode;
  logic [1:0] periphSel;
  logic [3:0] periphReady;
  logic       instReady, branch, accEn, bitRamEn, bitRamRw, byteRamEn, byteRamRw;
  logic       inputRead, outputRw, periphRw, periphTimeout, illegalInst;
  logic [2:0] accMuxSel;
  logic [1:0] op2MuxSel;
  logic [3:0] aluOpcode;
  logic [3:0] periphReq;

  int total = 0;
  int bad   = 0;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [4:0] NOP = 5'd0, LD = 5'd1, LDN = 5'd2, ST = 5'd3, AND_ = 5'd4, OR_ = 5'd5;
  localparam logic [4:0] XOR_ = 5'd6, ADD = 5'd7, SUB = 5'd8, JMP = 5'd9, JMPC = 5'd10, JMPCN = 5'd11;

  il_ctrl_pipe #(
    .OPCODE_W(5), .NUM_PERIPH(4), .PSEL_W(2), .TIMEOUT_CYC(4), .BRANCH_SHADOW(1)
  ) dut (
    .clk(clk), .reset(reset), .instValid(instValid), .instOpCode(instOpCode),
    .iomemCode(iomemCode), .periphSel(periphSel), .acc0(acc0), .periphReady(periphReady),
    .instReady(instReady), .branch(branch), .accMuxSel(accMuxSel), .accEn(accEn),
    .op2MuxSel(op2MuxSel), .aluOpcode(aluOpcode), .bitRamEn(bitRamEn), .bitRamRw(bitRamRw),
    .byteRamEn(byteRamEn), .byteRamRw(byteRamRw), .inputRead(inputRead), .outputRw(outputRw),
    .periphReq(periphReq), .periphRw(periphRw), .periphTimeout(periphTimeout),
    .illegalInst(illegalInst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  io;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[14];

  // {instReady, branch, accEn, accMuxSel, aluOpcode,
  //  inputRead, outputRw, bitRamEn, bitRamRw, byteRamEn, byteRamRw,
  //  periphReq, periphRw, periphTimeout, illegalInst, op2MuxSel}
  function automatic logic [24:0] mk(input logic rdy, input logic br, input logic ae,
                                     input logic [2:0] mux, input logic [3:0] alu,
                                     input logic [5:0] strb, input logic [3:0] req,
                                     input logic rw, input logic to, input logic ill,
                                     input logic [1:0] op2);
    return {rdy, br, ae, mux, alu, strb, req, rw, to, ill, op2};
  endfunction

  function automatic logic [24:0] obs();
    return {instReady, branch, accEn, accMuxSel, aluOpcode,
            inputRead, outputRw, bitRamEn, bitRamRw, byteRamEn, byteRamRw,
            periphReq, periphRw, periphTimeout, illegalInst, op2MuxSel};
  endfunction

  task automatic check(input string name, input logic [24:0] exp);
    logic [24:0] got;
    got = obs();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instValid = 1'b0; acc0 = 1'b0; instOpCode = NOP;
    iomemCode = 2'b00; periphSel = 2'd0; periphReady = 4'd0;

    tbl[0]  = '{LD,    2'b00, mk(Y, N, Y, 3'd0, 4'd0, 6'b100000, 4'd0, N, N, N, 2'b00)};
    tbl[1]  = '{ADD,   2'b01, mk(Y, N, Y, 3'd4, 4'd5, 6'b001000, 4'd0, N, N, N, 2'b01)};
    tbl[2]  = '{ST,    2'b10, mk(Y, N, N, 3'd0, 4'd0, 6'b000011, 4'd0, N, N, N, 2'b10)};
    tbl[3]  = '{LDN,   2'b10, mk(Y, N, Y, 3'd2, 4'd1, 6'b000010, 4'd0, N, N, N, 2'b10)};
    tbl[4]  = '{AND_,  2'b00, mk(Y, N, Y, 3'd4, 4'd2, 6'b100000, 4'd0, N, N, N, 2'b00)};
    tbl[5]  = '{OR_,   2'b10, mk(Y, N, Y, 3'd4, 4'd3, 6'b000010, 4'd0, N, N, N, 2'b10)};
    tbl[6]  = '{XOR_,  2'b01, mk(Y, N, Y, 3'd4, 4'd4, 6'b001000, 4'd0, N, N, N, 2'b01)};
    tbl[7]  = '{SUB,   2'b00, mk(Y, N, Y, 3'd4, 4'd6, 6'b100000, 4'd0, N, N, N, 2'b00)};
    tbl[8]  = '{ST,    2'b00, mk(Y, N, N, 3'd0, 4'd0, 6'b010000, 4'd0, N, N, N, 2'b00)};
    tbl[9]  = '{ST,    2'b01, mk(Y, N, N, 3'd0, 4'd0, 6'b001100, 4'd0, N, N, N, 2'b01)};
    tbl[10] = '{NOP,   2'b01, mk(Y, N, N, 3'd0, 4'd0, 6'b000000, 4'd0, N, N, N, 2'b01)};
    tbl[11] = '{5'd31, 2'b00, mk(Y, N, N, 3'd0, 4'd0, 6'b000000, 4'd0, N, N, Y, 2'b00)};
    tbl[12] = '{LD,    2'b01, mk(Y, N, Y, 3'd1, 4'd0, 6'b001000, 4'd0, N, N, N, 2'b01)};
    tbl[13] = '{5'd12, 2'b10, mk(Y, N, N, 3'd0, 4'd0, 6'b000000, 4'd0, N, N, Y, 2'b10)};

    step(); step();
    check("reset", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b00));
    reset = 1'b0;

    instValid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      instOpCode = tbl[i].op;
      iomemCode  = tbl[i].io;
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    instValid = 1'b0;
    step();

    // peripheral LD on channel 2, ready in third wait cycle; other channels ready early
    instValid = 1'b1; instOpCode = LD; iomemCode = 2'b11; periphSel = 2'd2;
    step();
    instValid = 1'b0; periphReady = 4'b1011;
    check("pld_w1", mk(N, N, N, 3'd0, 4'd0, 6'd0, 4'b0100, N, N, N, 2'b11));
    step();
    check("pld_w2", mk(N, N, N, 3'd0, 4'd0, 6'd0, 4'b0100, N, N, N, 2'b11));
    step();
    check("pld_w3", mk(N, N, N, 3'd0, 4'd0, 6'd0, 4'b0100, N, N, N, 2'b11));
    periphReady = 4'b0100;
    step();
    check("pld_done", mk(Y, N, Y, 3'd3, 4'd0, 6'd0, 4'd0, N, N, N, 2'b11));
    periphReady = 4'd0;
    step();
    check("pld_idle", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b11));

    // peripheral ST on channel 1, never ready: times out after 4 wait cycles
    instValid = 1'b1; instOpCode = ST; iomemCode = 2'b11; periphSel = 2'd1;
    step();
    instValid = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      check($sformatf("pst_w%0d", w), mk(N, N, N, 3'd0, 4'd0, 6'd0, 4'b0010, Y, N, N, 2'b11));
      step();
    end
    check("pst_timeout", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, Y, N, 2'b11));
    step();
    check("pst_idle", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b11));

    // peripheral ADD on channel 0, ready arrives in the last wait cycle: ready wins
    instValid = 1'b1; instOpCode = ADD; iomemCode = 2'b11; periphSel = 2'd0;
    step();
    instValid = 1'b0;
    step(); step(); step();
    check("prt_w4", mk(N, N, N, 3'd0, 4'd0, 6'd0, 4'b0001, N, N, N, 2'b11));
    periphReady = 4'b0001;
    step();
    check("prt_done", mk(Y, N, Y, 3'd4, 4'd5, 6'd0, 4'd0, N, N, N, 2'b11));
    periphReady = 4'd0;
    step();
    check("prt_idle", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b11));

    // JMPC taken, following ST is dropped
    instValid = 1'b1; instOpCode = JMPC; iomemCode = 2'b00; acc0 = 1'b1;
    step();
    check("jmpc_taken", mk(Y, Y, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b00));
    instOpCode = ST; iomemCode = 2'b01;
    step();
    instValid = 1'b0;
    check("jmpc_drop", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b00));
    step();

    // JMPC not taken, following ST executes
    instValid = 1'b1; instOpCode = JMPC; iomemCode = 2'b00; acc0 = 1'b0;
    step();
    check("jmpc_nt", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b00));
    instOpCode = ST; iomemCode = 2'b01;
    step();
    instValid = 1'b0;
    check("jmpc_nt_st", mk(Y, N, N, 3'd0, 4'd0, 6'b001100, 4'd0, N, N, N, 2'b01));
    step();

    // JMPCN taken on acc0=0; dropped illegal opcode raises nothing
    instValid = 1'b1; instOpCode = JMPCN; iomemCode = 2'b10; acc0 = 1'b0;
    step();
    check("jmpcn_taken", mk(Y, Y, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b10));
    instOpCode = 5'd31; iomemCode = 2'b00;
    step();
    instValid = 1'b0;
    check("jmpcn_drop", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b10));
    step();

    // unconditional JMP ignores acc0
    instValid = 1'b1; instOpCode = JMP; iomemCode = 2'b01; acc0 = 1'b1;
    step();
    check("jmp_taken", mk(Y, Y, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b01));
    instOpCode = LD; iomemCode = 2'b00;
    step();
    instValid = 1'b0;
    check("jmp_drop", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b01));
    step();

    // reset asserted while waiting on a peripheral
    instValid = 1'b1; instOpCode = LD; iomemCode = 2'b11; periphSel = 2'd3;
    step();
    instValid = 1'b0;
    check("rst_w1", mk(N, N, N, 3'd0, 4'd0, 6'd0, 4'b1000, N, N, N, 2'b11));
    reset = 1'b1;
    step();
    check("rst_pwait", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b00));
    reset = 1'b0;
    step();
    check("rst_after", mk(Y, N, N, 3'd0, 4'd0, 6'd0, 4'd0, N, N, N, 2'b00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/il_ctrl_pipe.md
# il_ctrl_pipe

Parametrised, registered control unit for the instruction-list pipelined processor. It replaces the single-cycle combinational decoder with a one-stage decode/execute register. It adds a stall/handshake path to N memory-mapped peripherals with a timeout, and conditional-branch resolution on `acc0` with a configurable fetch-shadow flush. It sits between the instruction fetch stage and the datapath (accumulator mux, ALU, bit/byte RAM, I/O, peripherals).

## Interface
- `OPCODE_W`, 5: opcode width; decoded values are zero-extended constants below.
- `NUM_PERIPH`, 4: number of peripheral channels (timer/counter, UART, SPI, spare).
- `PSEL_W`, 2: peripheral select width, ≥ clog2(NUM_PERIPH).
- `TIMEOUT_CYC`, 255: maximum wait cycles for a peripheral handshake, 1..2^16-1.
- `BRANCH_SHADOW`, 1: number of fetch slots discarded after a taken branch, 0..3.

Ports:
- `clk` in 1: single clock; all state rises on posedge.
- `reset` in 1: synchronous, active-high.
- `instValid` in 1: fetch presents an instruction.
- `instOpCode` in OPCODE_W: opcode.
- `iomemCode` in 2: operand space; 00 input/output, 01 bit RAM, 10 byte RAM, 11 peripheral.
- `periphSel` in PSEL_W: peripheral channel for iomemCode=11.
- `acc0` in 1: accumulator bit 0, current registered value.
- `periphReady` in NUM_PERIPH: per-channel completion strobe.
- `instReady` out 1: control unit accepts an instruction this cycle.
- `branch` out 1: taken-branch pulse; fetch loads the jump target.
- `accMuxSel` out 3: 0 input, 1 bit RAM, 2 byte RAM, 3 peripheral, 4 ALU result.
- `accEn` out 1: accumulator write.
- `op2MuxSel` out 2: ALU operand 2 source, equal to the latched iomemCode.
- `aluOpcode` out 4: 0 pass, 1 not, 2 and, 3 or, 4 xor, 5 add, 6 sub.
- `bitRamEn`, `bitRamRw`, `byteRamEn`, `byteRamRw` out 1 each: RAM strobes; Rw=1 is write.
- `inputRead`, `outputRw` out 1 each: I/O read strobe, output write strobe.
- `periphReq` out NUM_PERIPH: one-hot request, held until done.
- `periphRw` out 1: 1 write, 0 read; valid while any `periphReq` bit is high.
- `periphTimeout` out 1: one-cycle pulse on an abandoned handshake.
- `illegalInst` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Opcodes: 0 NOP, 1 LD, 2 LDN, 3 ST, 4 AND, 5 OR, 6 XOR, 7 ADD, 8 SUB, 9 JMP, 10 JMPC (taken if acc0=1), 11 JMPCN (taken if acc0=0). Every other opcode executes as NOP and pulses `illegalInst`.
- Accept: a handshake occurs when `instValid && instReady`. It latches the opcode, iomemCode and periphSel into the execute register (EX).
- States:
  - RUN: `instReady`=1.
  - PWAIT: peripheral handshake in progress; `instReady`=0.
  - SHADOW: discarding fetch slots; `instReady`=1 but accepted instructions are dropped.
- LD/LDN/ALU ops with iomemCode≠11 (RUN, EX cycle):
  - Assert the source strobe: `inputRead`, `bitRamEn` with Rw=0, or `byteRamEn` with Rw=0.
  - Assert `accEn`=1.
  - `accMuxSel`: source for LD/LDN, 4 for ALU ops.
  - `aluOpcode`: LDN=not, ALU ops per map.
- ST with iomemCode≠11: assert `outputRw`, `bitRamEn`+`bitRamRw`, or `byteRamEn`+`byteRamRw` (space-selected); `accEn`=0.
- Any LD/LDN/ST/ALU op with iomemCode=11:
  - EX: `periphReq[periphSel]`=1, `periphRw`=(op==ST); go to PWAIT; the timeout counter clears to 0.
  - PWAIT: the counter increments each cycle `periphReady[periphSel]`=0.
  - `periphReady[periphSel]`=1 sampled: the next cycle drops `periphReq` and asserts `accEn` (loads; `accMuxSel`=3 for LD/LDN, 4 for ALU) for one cycle, then returns to RUN.
  - Counter reaches TIMEOUT_CYC: the next cycle drops `periphReq`, pulses `periphTimeout`, does not assert `accEn`, and returns to RUN.
  - `periphReady` bits of other channels are ignored.
- Jumps: resolved in the EX cycle. If taken, `branch`=1 for that cycle. The instruction accepted in that cycle and the next BRANCH_SHADOW-1 accepts are discarded (SHADOW state). BRANCH_SHADOW=0 discards none.
- Not-taken conditional jump: behaves as NOP.

## Timing
- Reset (sync): every output is 0 except `instReady`=1; state RUN; EX holds NOP; the counter clears. Reset during PWAIT drops `periphReq` on the next edge with no timeout pulse.
- Latency: accept at edge N; datapath strobes, `branch` and `periphReq` are registered and valid in cycle N+1. Non-peripheral ops sustain 1 instruction/cycle.
- Peripheral op with ready in wait cycle k (k≥1): `accEn` is in cycle N+1+k; `instReady` returns to 1 in the same cycle.
- Ready and timeout in the same cycle: ready wins; no timeout pulse.
- `illegalInst` and the datapath strobes are mutually exclusive; a dropped shadow instruction produces no strobes, not even `illegalInst`.
- The counter is 16 bits and saturates; no wrap.

## Test plan
- Reset, then stream LD(00), ADD(01), ST(10) on consecutive cycles: `inputRead`+`accEn` with mux 0, then `bitRamEn`+`accEn` with mux 4 and alu 5, then `byteRamEn`+`byteRamRw`, each exactly one cycle later; `instReady` stays 1.
- LD periph sel=2, ready after 3 cycles: `periphReq`=0100 for 3 cycles, then `accEn` with mux 3; `instReady` low for 3 cycles.
- ST periph sel=1, no ready, TIMEOUT_CYC=4: req high for 4 wait cycles, then `periphTimeout` pulse, no `accEn`, `instReady` back to 1.
- JMPC with acc0=1 and BRANCH_SHADOW=1, followed by ST: `branch` pulses; the ST produces no strobe. JMPC with acc0=0: no branch, and the ST executes.
- Opcode 31: `illegalInst` pulse, all strobes 0. Reset asserted mid-PWAIT: `periphReq` clears next edge and `instReady`=1.
